// File: rtl/axi_port_slice.sv
// rtl/axi_port_slice.sv - five-channel AXI register slice built from two-entry skid buffers
//
// axi_port_slice_skid: one channel's two-entry skid buffer.
//   clk, reset         clock, synchronous active-low reset
//   in_valid/in_ready  source handshake; in_ready comes straight from a flop
//   in_payload         source payload, captured as-is
//   out_valid/out_ready sink handshake; out_valid comes straight from a flop
//   out_payload        oldest buffered entry (head register)
//   empty_next         buffer will be empty after this edge (feeds the registered idle)
//
// axi_port_slice: AW, W, AR forwarded S_ -> M_; B, R returned M_ -> S_.
//   idle               registered; high when all five buffers are empty

module axi_port_slice_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_payload,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_payload,
    output logic             empty_next
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_e;

    count_e             count_q, count_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic [WIDTH-1:0]   tail_q, tail_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic               push;
    logic               pop;

    // Handshakes use the registered valid/ready, so nothing on the
    // source side reaches the sink side combinationally and vice versa.
    assign push        = in_valid & ready_q;
    assign pop         = valid_q & out_ready;
    assign in_ready    = ready_q;
    assign out_valid   = valid_q;
    assign out_payload = head_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            EMPTY: begin
                if (push) begin
                    count_d = ONE;
                    head_d  = in_payload;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    count_d = FULL;
                    tail_d  = in_payload;
                end else if (push && pop) begin
                    head_d  = in_payload;
                end else if (pop) begin
                    count_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    count_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: begin
                count_d = EMPTY;
            end
        endcase
        valid_d    = (count_d != EMPTY);
        ready_d    = (count_d != FULL);
        empty_next = (count_d == EMPTY);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Payload holds are don't-care while empty, so they carry no reset.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

endmodule

module axi_port_slice #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 64,
    parameter int ID_BITS   = 4,
    parameter int LEN_BITS  = 4,
    parameter int SIZE_BITS = 2
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   S_AWVALID,
    output logic                   S_AWREADY,
    input  logic [ID_BITS-1:0]     S_AWID,
    input  logic [ADDR_BITS-1:0]   S_AWADDR,
    input  logic [LEN_BITS-1:0]    S_AWLEN,
    input  logic [SIZE_BITS-1:0]   S_AWSIZE,
    output logic                   M_AWVALID,
    input  logic                   M_AWREADY,
    output logic [ID_BITS-1:0]     M_AWID,
    output logic [ADDR_BITS-1:0]   M_AWADDR,
    output logic [LEN_BITS-1:0]    M_AWLEN,
    output logic [SIZE_BITS-1:0]   M_AWSIZE,

    input  logic                   S_WVALID,
    output logic                   S_WREADY,
    input  logic [ID_BITS-1:0]     S_WID,
    input  logic [DATA_BITS-1:0]   S_WDATA,
    input  logic [DATA_BITS/8-1:0] S_WSTRB,
    input  logic                   S_WLAST,
    output logic                   M_WVALID,
    input  logic                   M_WREADY,
    output logic [ID_BITS-1:0]     M_WID,
    output logic [DATA_BITS-1:0]   M_WDATA,
    output logic [DATA_BITS/8-1:0] M_WSTRB,
    output logic                   M_WLAST,

    input  logic                   S_ARVALID,
    output logic                   S_ARREADY,
    input  logic [ID_BITS-1:0]     S_ARID,
    input  logic [ADDR_BITS-1:0]   S_ARADDR,
    input  logic [LEN_BITS-1:0]    S_ARLEN,
    input  logic [SIZE_BITS-1:0]   S_ARSIZE,
    output logic                   M_ARVALID,
    input  logic                   M_ARREADY,
    output logic [ID_BITS-1:0]     M_ARID,
    output logic [ADDR_BITS-1:0]   M_ARADDR,
    output logic [LEN_BITS-1:0]    M_ARLEN,
    output logic [SIZE_BITS-1:0]   M_ARSIZE,

    input  logic                   M_BVALID,
    output logic                   M_BREADY,
    input  logic [ID_BITS-1:0]     M_BID,
    input  logic [1:0]             M_BRESP,
    output logic                   S_BVALID,
    input  logic                   S_BREADY,
    output logic [ID_BITS-1:0]     S_BID,
    output logic [1:0]             S_BRESP,

    input  logic                   M_RVALID,
    output logic                   M_RREADY,
    input  logic [ID_BITS-1:0]     M_RID,
    input  logic [DATA_BITS-1:0]   M_RDATA,
    input  logic [1:0]             M_RRESP,
    input  logic                   M_RLAST,
    output logic                   S_RVALID,
    input  logic                   S_RREADY,
    output logic [ID_BITS-1:0]     S_RID,
    output logic [DATA_BITS-1:0]   S_RDATA,
    output logic [1:0]             S_RRESP,
    output logic                   S_RLAST,

    output logic                   idle
);

    localparam int AX_W = ID_BITS + ADDR_BITS + LEN_BITS + SIZE_BITS;
    localparam int W_W  = ID_BITS + DATA_BITS + DATA_BITS / 8 + 1;
    localparam int B_W  = ID_BITS + 2;
    localparam int R_W  = ID_BITS + DATA_BITS + 2 + 1;

    logic aw_empty, w_empty, ar_empty, b_empty, r_empty;
    logic idle_q, idle_d;

    axi_port_slice_skid #(.WIDTH(AX_W)) u_aw (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (S_AWVALID),
        .in_ready    (S_AWREADY),
        .in_payload  ({S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE}),
        .out_valid   (M_AWVALID),
        .out_ready   (M_AWREADY),
        .out_payload ({M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE}),
        .empty_next  (aw_empty)
    );

    axi_port_slice_skid #(.WIDTH(W_W)) u_w (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (S_WVALID),
        .in_ready    (S_WREADY),
        .in_payload  ({S_WID, S_WDATA, S_WSTRB, S_WLAST}),
        .out_valid   (M_WVALID),
        .out_ready   (M_WREADY),
        .out_payload ({M_WID, M_WDATA, M_WSTRB, M_WLAST}),
        .empty_next  (w_empty)
    );

    axi_port_slice_skid #(.WIDTH(AX_W)) u_ar (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (S_ARVALID),
        .in_ready    (S_ARREADY),
        .in_payload  ({S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE}),
        .out_valid   (M_ARVALID),
        .out_ready   (M_ARREADY),
        .out_payload ({M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE}),
        .empty_next  (ar_empty)
    );

    axi_port_slice_skid #(.WIDTH(B_W)) u_b (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (M_BVALID),
        .in_ready    (M_BREADY),
        .in_payload  ({M_BID, M_BRESP}),
        .out_valid   (S_BVALID),
        .out_ready   (S_BREADY),
        .out_payload ({S_BID, S_BRESP}),
        .empty_next  (b_empty)
    );

    axi_port_slice_skid #(.WIDTH(R_W)) u_r (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (M_RVALID),
        .in_ready    (M_RREADY),
        .in_payload  ({M_RID, M_RDATA, M_RRESP, M_RLAST}),
        .out_valid   (S_RVALID),
        .out_ready   (S_RREADY),
        .out_payload ({S_RID, S_RDATA, S_RRESP, S_RLAST}),
        .empty_next  (r_empty)
    );

    // Built from next-state emptiness so the registered idle lines up
    // with the buffer counts of the same cycle.
    always_comb begin
        idle_d = aw_empty & w_empty & ar_empty & b_empty & r_empty;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_q <= 1'b1;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign idle = idle_q;

endmodule

// File: tb/tb_axi_port_slice.sv
// tb/tb_axi_port_slice.sv - self-checking bench for axi_port_slice

module tb_axi_port_slice;

    logic        clk = 1'b0;
    logic        reset;

    logic        S_AWVALID, S_AWREADY, M_AWVALID, M_AWREADY;
    logic [3:0]  S_AWID, M_AWID, S_AWLEN, M_AWLEN;
    logic [31:0] S_AWADDR, M_AWADDR;
    logic [1:0]  S_AWSIZE, M_AWSIZE;

    logic        S_WVALID, S_WREADY, M_WVALID, M_WREADY, S_WLAST, M_WLAST;
    logic [3:0]  S_WID, M_WID;
    logic [63:0] S_WDATA, M_WDATA;
    logic [7:0]  S_WSTRB, M_WSTRB;

    logic        S_ARVALID, S_ARREADY, M_ARVALID, M_ARREADY;
    logic [3:0]  S_ARID, M_ARID, S_ARLEN, M_ARLEN;
    logic [31:0] S_ARADDR, M_ARADDR;
    logic [1:0]  S_ARSIZE, M_ARSIZE;

    logic        M_BVALID, M_BREADY, S_BVALID, S_BREADY;
    logic [3:0]  M_BID, S_BID;
    logic [1:0]  M_BRESP, S_BRESP;

    logic        M_RVALID, M_RREADY, S_RVALID, S_RREADY, M_RLAST, S_RLAST;
    logic [3:0]  M_RID, S_RID;
    logic [63:0] M_RDATA, S_RDATA;
    logic [1:0]  M_RRESP, S_RRESP;

    logic        idle;

    always #5 clk = ~clk;

    axi_port_slice dut (
        .clk(clk), .reset(reset),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWID(S_AWID),
        .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWID(M_AWID),
        .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WID(S_WID),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WID(M_WID),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARID(S_ARID),
        .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARID(M_ARID),
        .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BID(M_BID), .M_BRESP(M_BRESP),
        .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BID(S_BID), .S_BRESP(S_BRESP),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RID(M_RID),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RID(S_RID),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .idle(idle)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Channel view: 0=AW 1=W 2=AR 3=B 4=R
    logic         src_valid [5];
    logic [127:0] src_pay   [5];
    logic         snk_ready [5];
    logic         dut_ovalid[5];
    logic         dut_iready[5];
    logic [127:0] dut_opay  [5];
    string        chname [5] = '{"aw", "w", "ar", "b", "r"};

    assign src_valid[0] = S_AWVALID;  assign snk_ready[0] = M_AWREADY;
    assign src_valid[1] = S_WVALID;   assign snk_ready[1] = M_WREADY;
    assign src_valid[2] = S_ARVALID;  assign snk_ready[2] = M_ARREADY;
    assign src_valid[3] = M_BVALID;   assign snk_ready[3] = S_BREADY;
    assign src_valid[4] = M_RVALID;   assign snk_ready[4] = S_RREADY;
    assign src_pay[0] = 128'({S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE});
    assign src_pay[1] = 128'({S_WID, S_WDATA, S_WSTRB, S_WLAST});
    assign src_pay[2] = 128'({S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE});
    assign src_pay[3] = 128'({M_BID, M_BRESP});
    assign src_pay[4] = 128'({M_RID, M_RDATA, M_RRESP, M_RLAST});
    assign dut_ovalid[0] = M_AWVALID; assign dut_iready[0] = S_AWREADY;
    assign dut_ovalid[1] = M_WVALID;  assign dut_iready[1] = S_WREADY;
    assign dut_ovalid[2] = M_ARVALID; assign dut_iready[2] = S_ARREADY;
    assign dut_ovalid[3] = S_BVALID;  assign dut_iready[3] = M_BREADY;
    assign dut_ovalid[4] = S_RVALID;  assign dut_iready[4] = M_RREADY;
    assign dut_opay[0] = 128'({M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE});
    assign dut_opay[1] = 128'({M_WID, M_WDATA, M_WSTRB, M_WLAST});
    assign dut_opay[2] = 128'({M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE});
    assign dut_opay[3] = 128'({S_BID, S_BRESP});
    assign dut_opay[4] = 128'({S_RID, S_RDATA, S_RRESP, S_RLAST});

    // Reference: each channel is an in-order FIFO of capacity two.
    logic [127:0] mq [5][2];
    int           mcnt [5];
    logic         chk_en = 1'b0;

    always @(posedge clk) begin
        for (int c = 0; c < 5; c++) begin
            if (!reset) begin
                mcnt[c] = 0;
            end else begin
                automatic bit do_push = src_valid[c] && (mcnt[c] < 2);
                automatic bit do_pop  = (mcnt[c] > 0) && snk_ready[c];
                if (do_pop) begin
                    mq[c][0] = mq[c][1];
                    mcnt[c]--;
                end
                if (do_push) begin
                    mq[c][mcnt[c]] = src_pay[c];
                    mcnt[c]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit all_empty = 1'b1;
            for (int c = 0; c < 5; c++) begin
                check($sformatf("%s_out_valid", chname[c]), 128'(dut_ovalid[c]), 128'(mcnt[c] > 0));
                check($sformatf("%s_in_ready", chname[c]), 128'(dut_iready[c]), 128'(mcnt[c] < 2));
                if (mcnt[c] > 0) begin
                    check($sformatf("%s_payload", chname[c]), dut_opay[c], mq[c][0]);
                    all_empty = 1'b0;
                end
            end
            check("idle", 128'(idle), 128'(all_empty));
        end
    end

    // Delivery collectors for the return channels.
    int r_rx = 0;
    int b_rx = 0;
    always @(negedge clk) begin
        if (chk_en && S_RVALID && S_RREADY) begin
            check("r_order_data", 128'(S_RDATA), 128'({32'hCAFE_0000, r_rx}));
            r_rx++;
        end
        if (chk_en && S_BVALID && S_BREADY) begin
            check("b_beat", 128'({S_BID, S_BRESP}), 128'({4'd5, 2'b10}));
            b_rx++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  tmo;
        bit  acc;

        reset = 1'b0;
        S_AWVALID = 1'b1; S_AWID = 4'd0; S_AWADDR = 32'd0; S_AWLEN = 4'd0; S_AWSIZE = 2'd0;
        M_AWREADY = 1'b0;
        S_WVALID = 1'b1; S_WID = 4'd0; S_WDATA = 64'd0; S_WSTRB = 8'd0; S_WLAST = 1'b0;
        M_WREADY = 1'b0;
        S_ARVALID = 1'b1; S_ARID = 4'd0; S_ARADDR = 32'd0; S_ARLEN = 4'd0; S_ARSIZE = 2'd0;
        M_ARREADY = 1'b0;
        M_BVALID = 1'b1; M_BID = 4'd0; M_BRESP = 2'd0; S_BREADY = 1'b0;
        M_RVALID = 1'b1; M_RID = 4'd0; M_RDATA = 64'd0; M_RRESP = 2'd0; M_RLAST = 1'b0;
        S_RREADY = 1'b0;

        // Reset held three cycles with every source valid.
        step();
        chk_en = 1'b1;
        step();
        step();
        check("rst_valids", 128'({M_AWVALID, M_WVALID, M_ARVALID, S_BVALID, S_RVALID}), 128'(5'b00000));
        check("rst_readys", 128'({S_AWREADY, S_WREADY, S_ARREADY, M_BREADY, M_RREADY}), 128'(5'b11111));
        check("rst_idle", 128'(idle), 128'(1'b1));
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0; M_BVALID = 1'b0; M_RVALID = 1'b0;
        reset = 1'b1;
        step();

        // 16-beat W burst at full rate.
        M_WREADY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            S_WVALID = 1'b1; S_WID = 4'd3; S_WDATA = 64'(i); S_WSTRB = 8'hFF;
            S_WLAST = (i == 15);
            step();
            check("w_stream_valid", 128'(M_WVALID), 128'(1'b1));
            check("w_stream_data", 128'(M_WDATA), 128'(i));
            check("w_stream_last", 128'(M_WLAST), 128'(i == 15));
        end
        S_WVALID = 1'b0; S_WLAST = 1'b0;
        step();
        check("w_stream_drained", 128'(M_WVALID), 128'(1'b0));

        // AW sink stall with three requests.
        M_AWREADY = 1'b0;
        S_AWVALID = 1'b1; S_AWID = 4'd1; S_AWADDR = 32'h1000; S_AWLEN = 4'd3; S_AWSIZE = 2'd3;
        step();
        check("aw_first_ready", 128'(S_AWREADY), 128'(1'b1));
        check("aw_first_id", 128'(M_AWID), 128'(4'd1));
        S_AWID = 4'd2; S_AWADDR = 32'h2000;
        step();
        check("aw_full_ready", 128'(S_AWREADY), 128'(1'b0));
        S_AWID = 4'd3; S_AWADDR = 32'h3000;
        repeat (3) step();
        check("aw_held_ready", 128'(S_AWREADY), 128'(1'b0));
        check("aw_held_id", 128'(M_AWID), 128'(4'd1));
        M_AWREADY = 1'b1;
        step();
        check("aw_pop1_id", 128'(M_AWID), 128'(4'd2));
        check("aw_pop1_ready", 128'(S_AWREADY), 128'(1'b1));
        step();
        S_AWVALID = 1'b0;
        check("aw_pop2_id", 128'(M_AWID), 128'(4'd3));
        check("aw_pop2_addr", 128'(M_AWADDR), 128'(32'h3000));
        step();
        check("aw_done", 128'(M_AWVALID), 128'(1'b0));
        M_AWREADY = 1'b0;

        // 64-beat R stream, sink ready alternating every cycle.
        r_rx = 0; k = 0; tmo = 0;
        S_RREADY = 1'b0;
        while (k < 64 && tmo < 1000) begin
            M_RVALID = 1'b1; M_RID = k[3:0]; M_RDATA = {32'hCAFE_0000, k};
            M_RRESP = k[1:0]; M_RLAST = (k[1:0] == 2'd3);
            acc = M_RREADY;
            step();
            S_RREADY = ~S_RREADY;
            if (acc) k++;
            tmo++;
        end
        check("r_src_done", 128'(k), 128'(64));
        M_RVALID = 1'b0; S_RREADY = 1'b1;
        repeat (4) step();
        check("r_delivered", 128'(r_rx), 128'(64));

        // B return path with a random sink.
        b_rx = 0; k = 0; tmo = 0;
        while (k < 12 && tmo < 1000) begin
            M_BVALID = 1'b1; M_BID = 4'd5; M_BRESP = 2'b10;
            S_BREADY = 1'($urandom_range(0, 1));
            acc = M_BREADY;
            step();
            if (acc) k++;
            tmo++;
        end
        check("b_src_done", 128'(k), 128'(12));
        M_BVALID = 1'b0; S_BREADY = 1'b1;
        repeat (4) step();
        check("b_delivered", 128'(b_rx), 128'(12));

        // AR reset while two entries are buffered.
        M_ARREADY = 1'b0;
        S_ARVALID = 1'b1; S_ARID = 4'd7; S_ARADDR = 32'h7000;
        step();
        S_ARID = 4'd8; S_ARADDR = 32'h8000;
        step();
        S_ARVALID = 1'b0;
        check("ar_buffered_valid", 128'(M_ARVALID), 128'(1'b1));
        check("ar_buffered_ready", 128'(S_ARREADY), 128'(1'b0));
        check("ar_buffered_idle", 128'(idle), 128'(1'b0));
        reset = 1'b0;
        step();
        check("ar_rst_valid", 128'(M_ARVALID), 128'(1'b0));
        check("ar_rst_idle", 128'(idle), 128'(1'b1));
        check("ar_rst_ready", 128'(S_ARREADY), 128'(1'b1));
        reset = 1'b1; M_ARREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ar_discarded", 128'(M_ARVALID), 128'(1'b0));
        end
        S_ARVALID = 1'b1; S_ARID = 4'd9; S_ARADDR = 32'h9000;
        step();
        S_ARVALID = 1'b0;
        check("ar_after_valid", 128'(M_ARVALID), 128'(1'b1));
        check("ar_after_id", 128'(M_ARID), 128'(4'd9));
        step();
        check("ar_after_empty", 128'(M_ARVALID), 128'(1'b0));

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
